gcd_axil_slave: RTL and testbench
=================================

GCD_AXIL_SLAVE -- requirements
Module: gcd_axil_slave

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on rising aclk.
REQ-002 Parameter SHALL be ADDR_W, default 32, meaning AXI4-Lite address width.
REQ-003 Port SHALL be: aclk  in  1  system clock.
REQ-004 Port SHALL be: aresetn  in  1  synchronous active-low reset.
REQ-005 Port SHALL be: s_axi_awaddr  in  ADDR_W  write address.
REQ-006 Port SHALL be: s_axi_awvalid  in  1  write address valid.
REQ-007 Port SHALL be: s_axi_awready  out  1  write address accept.
REQ-008 Port SHALL be: s_axi_wdata  in  32  write data.
REQ-009 Port SHALL be: s_axi_wstrb  in  4  write byte strobes.
REQ-010 Port SHALL be: s_axi_wvalid  in  1  write data valid.
REQ-011 Port SHALL be: s_axi_wready  out  1  write data accept.
REQ-012 Port SHALL be: s_axi_bresp  out  2  write response.
REQ-013 Port SHALL be: s_axi_bvalid  out  1  write response valid.
REQ-014 Port SHALL be: s_axi_bready  in  1  write response accept.
REQ-015 Port SHALL be: s_axi_araddr  in  ADDR_W  read address.
REQ-016 Port SHALL be: s_axi_arvalid  in  1  read address valid.
REQ-017 Port SHALL be: s_axi_arready  out  1  read address accept.
REQ-018 Port SHALL be: s_axi_rdata  out  32  read data.
REQ-019 Port SHALL be: s_axi_rresp  out  2  read response.
REQ-020 Port SHALL be: s_axi_rvalid  out  1  read data valid.
REQ-021 Port SHALL be: s_axi_rready  in  1  read data accept.

Function
REQ-022 Register map SHALL be: 0x00 CTRL (write bit0=START, self-clearing; read bit0=BUSY, bit1=DONE); 0x04 A (RW); 0x08 B (RW); 0x0C R (RO, writes ignored).
REQ-023 AW and W channels SHALL be accepted independently, in the same or different cycles; each is latched on valid&ready, and its ready SHALL be low while latched or while bvalid=1.
REQ-024 Register write SHALL occur in the cycle after both AW and W are latched, honouring wstrb per byte on A and B; START SHALL take effect only when wstrb[0]=1 and wdata[0]=1.
REQ-025 bvalid SHALL rise in the same cycle the write is performed and SHALL hold until bready=1, after which both channels are re-armed.
REQ-026 arready SHALL be high whenever rvalid=0; rdata/rresp SHALL be registered, rvalid SHALL rise one cycle after AR handshake and hold until rready=1.
REQ-027 Addresses with any bit set above bit 3 SHALL return SLVERR (2'b10) with rdata=0 and no register effect; mapped addresses SHALL return OKAY (2'b00); address bits [1:0] SHALL be ignored.
REQ-028 Core FSM SHALL have states IDLE and CALC, with internal operands x, y (32-bit).
REQ-029 In IDLE, an accepted START SHALL copy A->x, B->y, clear DONE, set BUSY and enter CALC on the next cycle.
REQ-030 Each CALC cycle SHALL: if x=0 or y=0, set R=x|y; else if x=y, set R=x; else subtract the smaller from the larger. In the first two cases it SHALL also set DONE, clear BUSY and return to IDLE.
REQ-031 CALC cycle count SHALL equal the number of subtractions plus one: gcd(35,25) takes 5 cycles, gcd(128,72) takes 7 cycles, gcd(0,0) takes 1 cycle and gives R=0.
REQ-032 START while BUSY=1 SHALL be ignored; writes to A/B while BUSY SHALL update the registers but not x/y.
REQ-033 Read and write in the same cycle SHALL both proceed; a read of R in the cycle R updates SHALL return the prior value.

Reset
REQ-034 When aresetn=0 at a clock edge, the block SHALL abort any calculation, set FSM=IDLE, set A, B, R, x, y, BUSY and DONE to 0, drive all ready/valid outputs to 0, and drive bresp, rresp and rdata to 0.
REQ-035 awready, wready and arready SHALL be 1 from the first cycle after aresetn returns high.

Verification
REQ-036 A=35, B=25, START (AW and W one cycle apart), wait 10 cycles, read 0x0C -> rdata=5, rresp=OKAY; read 0x00 -> 0x2.
REQ-037 A=128, B=72, START, read 0x00 within 3 cycles -> BUSY=1; read 0x0C after 20 cycles -> rdata=8.
REQ-038 A=0, B=9, START -> R=9 after 1 CALC cycle; A=0, B=0 -> R=0.
REQ-039 Hold bready=0 for 5 cycles after a write -> bvalid held high and awready=0 until bready=1; repeat the test for rready/rvalid.
REQ-040 Write to 0x10, then read from 0x10 -> bresp=SLVERR and rresp=SLVERR with rdata=0; A, B and R unchanged.
REQ-041 Assert aresetn=0 mid-CALC -> BUSY=0, DONE=0, R=0 on the next cycle; a new START then computes correctly.

Source files
------------

// File: rtl/gcd_axil_slave.sv
// AXI4-Lite slave wrapping a subtract-based GCD engine.
// Registers: CTRL (START / BUSY,DONE), operands A and B, result R.
module gcd_axil_slave #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);
  localparam int unsigned DATA_W = 32;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                armed;
  logic                aw_lat, aw_map_q, w_lat;
  logic [1:0]          aw_idx_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [3:0]          wstrb_q;
  logic [DATA_W-1:0]   a_q, b_q, r_q, r_d, x_q, x_d, y_q, y_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                do_write, wr_ok, start_req, rd_map;
  logic [DATA_W-1:0]   rd_val;
  logic                unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  function automatic logic [DATA_W-1:0] apply_strb(input logic [DATA_W-1:0] cur,
                                                   input logic [DATA_W-1:0] nxt,
                                                   input logic [3:0]        strb);
    logic [DATA_W-1:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = nxt[8*i +: 8];
    end
    return res;
  endfunction

  assign do_write  = aw_lat & w_lat;
  assign wr_ok     = do_write & aw_map_q;
  assign start_req = wr_ok && (aw_idx_q == 2'd0) && wstrb_q[0] && wdata_q[0];

  // Read mux; any address bit above bit 3 is unmapped.
  always_comb begin
    rd_map = (s_axi_araddr[ADDR_W-1:4] == '0);
    rd_val = '0;
    case (s_axi_araddr[3:2])
      2'd0:    rd_val = {{(DATA_W-2){1'b0}}, done_q, busy_q};
      2'd1:    rd_val = a_q;
      2'd2:    rd_val = b_q;
      default: rd_val = r_q;
    endcase
    if (!rd_map) rd_val = '0;
  end

  // AXI-Lite channel handling and A/B register file.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      armed         <= 1'b0;
      aw_lat        <= 1'b0;
      aw_map_q      <= 1'b0;
      aw_idx_q      <= 2'd0;
      w_lat         <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      s_axi_awready <= 1'b0;
      s_axi_wready  <= 1'b0;
      s_axi_bvalid  <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_arready <= 1'b0;
      s_axi_rvalid  <= 1'b0;
      s_axi_rdata   <= '0;
      s_axi_rresp   <= RESP_OKAY;
    end else begin
      armed <= 1'b1;
      if (!armed) begin
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
        s_axi_arready <= 1'b1;
      end
      if (s_axi_awvalid && s_axi_awready) begin
        aw_lat        <= 1'b1;
        aw_map_q      <= (s_axi_awaddr[ADDR_W-1:4] == '0);
        aw_idx_q      <= s_axi_awaddr[3:2];
        s_axi_awready <= 1'b0;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_lat        <= 1'b1;
        wdata_q      <= s_axi_wdata;
        wstrb_q      <= s_axi_wstrb;
        s_axi_wready <= 1'b0;
      end
      if (do_write) begin
        aw_lat       <= 1'b0;
        w_lat        <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= aw_map_q ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok && aw_idx_q == 2'd1) a_q <= apply_strb(a_q, wdata_q, wstrb_q);
        if (wr_ok && aw_idx_q == 2'd2) b_q <= apply_strb(b_q, wdata_q, wstrb_q);
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid  <= 1'b0;
        s_axi_awready <= 1'b1;
        s_axi_wready  <= 1'b1;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_arready <= 1'b0;
        s_axi_rvalid  <= 1'b1;
        s_axi_rdata   <= rd_val;
        s_axi_rresp   <= rd_map ? RESP_OKAY : RESP_SLVERR;
      end
      if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid  <= 1'b0;
        s_axi_arready <= 1'b1;
      end
    end
  end

  // GCD core state register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // GCD core next state: one compare/subtract step per CALC cycle.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: begin
        if (start_req) begin
          x_d     = a_q;
          y_d     = b_q;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (x_q == '0 || y_q == '0) begin
          r_d     = x_q | y_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (x_q == y_q) begin
          r_d     = x_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_gcd_axil_slave.sv
// Randomised AXI-Lite bench for gcd_axil_slave with a transaction-level reference model.
module tb_gcd_axil_slave;
  localparam int unsigned ADDR_W = 32;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic [ADDR_W-1:0] s_axi_awaddr = '0;
  logic              s_axi_awvalid = 1'b0;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata = '0;
  logic [3:0]        s_axi_wstrb = '0;
  logic              s_axi_wvalid = 1'b0;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready = 1'b0;
  logic [ADDR_W-1:0] s_axi_araddr = '0;
  logic              s_axi_arvalid = 1'b0;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready = 1'b0;

  always #5 aclk = ~aclk;

  gcd_axil_slave #(.ADDR_W(ADDR_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: Euclid by division; CALC cycles = sum of quotients.
  function automatic logic [31:0] gcd_val(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] t;
    if (a == 0) return b;
    if (b == 0) return a;
    while (b != 0) begin t = a % b; a = b; b = t; end
    return a;
  endfunction

  function automatic int gcd_cycles(input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] t;
    if (a == 0 || b == 0) return 1;
    n = 0;
    while (b != 0) begin n = n + int'(a / b); t = a % b; a = b; b = t; end
    return n;
  endfunction

  // Model state.
  logic [31:0] m_a = '0, m_b = '0, m_r = '0, m_res = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  int          m_rem = 0;
  logic        started = 1'b0, armed = 1'b0, aw_got = 1'b0, w_got = 1'b0;
  logic        eb = 1'b0, er = 1'b0, busy_pre, eb_pre, er_pre;
  logic [31:0] aw_addr_m = '0, w_data_m = '0;
  logic [3:0]  w_strb_m = '0;
  logic [1:0]  ebresp = '0;
  logic [1:0]  aidx;
  logic [33:0] rq[$];

  function automatic logic [33:0] read_model(input logic [31:0] addr);
    logic [1:0] idx;
    if ((addr >> 4) != 0) return {2'b10, 32'h0};
    idx = addr[3:2];
    case (idx)
      2'd0:    return {2'b00, 30'h0, m_done, m_busy};
      2'd1:    return {2'b00, m_a};
      2'd2:    return {2'b00, m_b};
      default: return {2'b00, m_r};
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nxt,
                                        input logic [3:0] strb);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) if (strb[i]) res[8*i +: 8] = nxt[8*i +: 8];
    return res;
  endfunction

  always @(posedge aclk) begin
    started = 1'b1;
    if (!aresetn) begin
      m_a = '0; m_b = '0; m_r = '0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0;
      armed = 1'b0; aw_got = 1'b0; w_got = 1'b0; eb = 1'b0; er = 1'b0; ebresp = '0;
      rq.delete();
    end else begin
      busy_pre = m_busy; eb_pre = eb; er_pre = er;
      if (er_pre && s_axi_rready) begin
        if (rq.size() > 0) void'(rq.pop_front());
        er = 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        rq.push_back(read_model(s_axi_araddr));
        er = 1'b1;
      end
      if (busy_pre) begin
        m_rem--;
        if (m_rem == 0) begin m_r = m_res; m_busy = 1'b0; m_done = 1'b1; end
      end
      if (aw_got && w_got) begin
        aw_got = 1'b0; w_got = 1'b0; eb = 1'b1;
        if ((aw_addr_m >> 4) != 0) ebresp = 2'b10;
        else begin
          ebresp = 2'b00;
          aidx = aw_addr_m[3:2];
          if (aidx == 2'd1) m_a = merge(m_a, w_data_m, w_strb_m);
          if (aidx == 2'd2) m_b = merge(m_b, w_data_m, w_strb_m);
          if (aidx == 2'd0 && w_strb_m[0] && w_data_m[0] && !busy_pre) begin
            m_busy = 1'b1; m_done = 1'b0;
            m_rem = gcd_cycles(m_a, m_b); m_res = gcd_val(m_a, m_b);
          end
        end
      end else begin
        if (s_axi_awvalid && s_axi_awready) begin aw_got = 1'b1; aw_addr_m = s_axi_awaddr; end
        if (s_axi_wvalid && s_axi_wready) begin
          w_got = 1'b1; w_data_m = s_axi_wdata; w_strb_m = s_axi_wstrb;
        end
      end
      if (eb_pre && s_axi_bready) eb = 1'b0;
      armed = 1'b1;
    end
  end

  // Cycle-by-cycle comparison of all handshake outputs and response payloads.
  always @(negedge aclk) begin
    if (started) begin
      check("awready", 32'(s_axi_awready), 32'(armed && !aw_got && !eb));
      check("wready",  32'(s_axi_wready),  32'(armed && !w_got && !eb));
      check("arready", 32'(s_axi_arready), 32'(armed && !er));
      check("bvalid",  32'(s_axi_bvalid),  32'(eb));
      check("rvalid",  32'(s_axi_rvalid),  32'(er));
      if (eb) check("bresp", 32'(s_axi_bresp), 32'(ebresp));
      if (er && rq.size() > 0) begin
        check("rdata", s_axi_rdata, rq[0][31:0]);
        check("rresp", 32'(s_axi_rresp), 32'(rq[0][33:32]));
      end
      if (!aresetn && !armed) begin
        check("rst_rdata", s_axi_rdata, 32'h0);
        check("rst_bresp", 32'(s_axi_bresp), 32'h0);
        check("rst_rresp", 32'(s_axi_rresp), 32'h0);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly,
                           output logic [1:0] resp);
    int k;
    logic awd, wd, hs_aw, hs_w;
    s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
    k = 0; awd = 1'b0; wd = 1'b0;
    while (!(awd && wd) && k < 64) begin
      s_axi_awvalid = !awd && (k >= aw_dly);
      s_axi_wvalid  = !wd && (k >= w_dly);
      @(negedge aclk);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      @(posedge aclk); #1;
      if (hs_aw) awd = 1'b1;
      if (hs_w) wd = 1'b1;
      k++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("write_accept", 32'({awd, wd}), 32'h3);
    k = 0;
    while (!s_axi_bvalid && k < 16) begin cyc(1); k++; end
    check("bvalid_arrives", 32'(s_axi_bvalid), 32'h1);
    if (b_dly > 0) begin
      cyc(b_dly);
      check("bvalid_held", 32'(s_axi_bvalid), 32'h1);
      check("awready_low_while_bvalid", 32'(s_axi_awready), 32'h0);
    end
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    cyc(1);
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
    int k;
    logic hs;
    s_axi_araddr = addr; s_axi_arvalid = 1'b1;
    k = 0; hs = 1'b0;
    while (!hs && k < 32) begin
      @(negedge aclk);
      hs = s_axi_arready;
      @(posedge aclk); #1;
      k++;
    end
    s_axi_arvalid = 1'b0;
    check("read_accept", 32'(hs), 32'h1);
    k = 0;
    while (!s_axi_rvalid && k < 16) begin cyc(1); k++; end
    check("rvalid_arrives", 32'(s_axi_rvalid), 32'h1);
    if (r_dly > 0) begin
      cyc(r_dly);
      check("rvalid_held", 32'(s_axi_rvalid), 32'h1);
      check("arready_low_while_rvalid", 32'(s_axi_arready), 32'h0);
    end
    data = s_axi_rdata; resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    cyc(1);
    s_axi_rready = 1'b0;
  endtask

  logic [31:0] rd, wa, wdat, ra, rd2;
  logic [1:0]  rr, br, rr2, br2;
  logic [3:0]  ws;
  int          kind;
  logic [31:0] addr_tbl [0:8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h5, 32'h8000_0000};

  initial begin
    cyc(3);
    check("rst_awready", 32'(s_axi_awready), 32'h0);
    check("rst_arready", 32'(s_axi_arready), 32'h0);
    check("rst_bvalid",  32'(s_axi_bvalid),  32'h0);
    check("rst_rvalid",  32'(s_axi_rvalid),  32'h0);
    aresetn = 1'b1;
    cyc(1);
    check("awready_after_reset", 32'(s_axi_awready), 32'h1);
    check("wready_after_reset",  32'(s_axi_wready),  32'h1);
    check("arready_after_reset", 32'(s_axi_arready), 32'h1);

    // gcd(35,25) with W one cycle behind AW.
    axi_write(32'h4, 32'd35, 4'hF, 0, 0, 0, br);
    axi_write(32'h8, 32'd25, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'hF, 0, 1, 0, br);
    check("start_bresp", 32'(br), 32'h0);
    cyc(10);
    axi_read(32'hC, 0, rd, rr);
    check("gcd35_25", rd, 32'd5);
    check("gcd35_25_resp", 32'(rr), 32'h0);
    axi_read(32'h0, 0, rd, rr);
    check("ctrl_done", rd, 32'h2);

    // gcd(128,72): busy observed early, result later.
    axi_write(32'h4, 32'd128, 4'hF, 0, 0, 0, br);
    axi_write(32'h8, 32'd72, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'h1, 1, 0, 0, br);
    axi_read(32'h0, 0, rd, rr);
    check("ctrl_busy", rd, 32'h1);
    cyc(20);
    axi_read(32'hC, 0, rd, rr);
    check("gcd128_72", rd, 32'd8);

    // Zero operands.
    axi_write(32'h4, 32'd0, 4'hF, 0, 0, 0, br);
    axi_write(32'h8, 32'd9, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'hF, 0, 0, 0, br);
    axi_read(32'hC, 0, rd, rr);
    check("gcd0_9", rd, 32'd9);
    axi_write(32'h8, 32'd0, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'hF, 0, 0, 0, br);
    cyc(2);
    axi_read(32'hC, 0, rd, rr);
    check("gcd0_0", rd, 32'd0);

    // Response back-pressure, partial strobe, and ignored low address bits.
    axi_write(32'h4, 32'h1234_5607, 4'h1, 0, 0, 5, br);
    axi_read(32'h7, 5, rd, rr);
    check("a_strb_lsb", rd, 32'h7);

    // Unmapped address.
    axi_write(32'h10, 32'hDEAD, 4'hF, 0, 0, 0, br);
    check("unmapped_bresp", 32'(br), 32'h2);
    axi_read(32'h10, 0, rd, rr);
    check("unmapped_rresp", 32'(rr), 32'h2);
    check("unmapped_rdata", rd, 32'h0);
    axi_read(32'h4, 0, rd, rr);
    check("a_unchanged", rd, 32'h7);
    axi_read(32'hC, 0, rd, rr);
    check("r_unchanged", rd, 32'h0);

    // Reset in the middle of a long calculation.
    axi_write(32'h4, 32'd200, 4'hF, 0, 0, 0, br);
    axi_write(32'h8, 32'd3, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'hF, 0, 0, 0, br);
    cyc(3);
    aresetn = 1'b0;
    cyc(1);
    aresetn = 1'b1;
    cyc(1);
    axi_read(32'h0, 0, rd, rr);
    check("ctrl_after_reset", rd, 32'h0);
    axi_read(32'hC, 0, rd, rr);
    check("r_after_reset", rd, 32'h0);
    axi_write(32'h4, 32'd35, 4'hF, 0, 0, 0, br);
    axi_write(32'h8, 32'd25, 4'hF, 0, 0, 0, br);
    axi_write(32'h0, 32'd1, 4'hF, 0, 0, 0, br);
    cyc(8);
    axi_read(32'hC, 0, rd, rr);
    check("gcd_after_reset", rd, 32'd5);

    // Random traffic, including concurrent read and write.
    for (int it = 0; it < 60; it++) begin
      kind = int'($urandom_range(0, 3));
      wa   = addr_tbl[$urandom_range(0, 8)];
      ra   = addr_tbl[$urandom_range(0, 8)];
      wdat = 32'($urandom_range(0, 255));
      ws   = 4'($urandom_range(0, 15));
      if (kind == 3) begin wa = 32'h0; wdat = 32'h1; ws = 4'hF; end
      if (kind == 1) begin
        axi_read(ra, int'($urandom_range(0, 3)), rd, rr);
      end else if (kind == 2) begin
        fork
          axi_write(wa, wdat, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)), br);
          axi_read(ra, int'($urandom_range(0, 3)), rd2, rr2);
        join
      end else begin
        axi_write(wa, wdat, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 3)), br2);
      end
      cyc(int'($urandom_range(0, 6)));
    end

    cyc(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
